// File: rtl/mpeg_fifo_pkg.sv
// Shared helpers for the MPEG clock-crossing FIFO pointer logic.
// Gray/binary conversion, byte reverse and synchroniser depth.
package mpeg_fifo_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int PTR_MAX     = 32;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits leave the prefix-xor unchanged, so any narrower width works.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [31:0] byte_rev32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mpeg_gray_ptr_sync.sv
// Multi-flop synchroniser for a foreign Gray pointer, decoded to binary.
// Shared by the read- and write-side FIFO controllers.
module mpeg_gray_ptr_sync
    import mpeg_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] wsync_bin
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign wsync_bin = W'(gray2bin(ptr_t'(sync_q[SYNC_STAGES-1])));

endmodule

// File: rtl/mpeg_fifo_rd_ctrl.sv
// Read-side CDC FIFO controller with a 2-entry FWFT output buffer.
// Optional MPEG_FIFO_BYTESWAP_EN byte-reverses the output word (32-bit only).
module mpeg_fifo_rd_ctrl
    import mpeg_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   ram_level
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wsync_bin;
    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  pop, push, fetch;
    logic [1:0]            occ_mp;
    logic [2:0]            pend;

    mpeg_gray_ptr_sync #(.W(PW)) u_wsync (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .gray_in   (wptr_gray),
        .wsync_bin (wsync_bin)
    );

    assign empty     = (rbin_q == wsync_bin);
    assign ram_level = wsync_bin - rbin_q;
    assign ram_raddr = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray = rptr_gray_q;
    assign valid     = (occ_q != 2'd0);

    always_comb begin
        pop    = valid & ready;
        push   = inflight_q;
        occ_mp = occ_q - {1'b0, pop};
        // Words already owned by the buffer once this edge's pop is taken.
        pend   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
        fetch  = !empty && (pend <= 3'd1);

        rbin_d      = rbin_q + PW'(fetch);
        rptr_gray_d = PW'(bin2gray(ptr_t'(rbin_d)));
        inflight_d  = fetch;

        head_d = head_q;
        tail_d = tail_q;
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (occ_mp == 2'd0) begin
                head_d = ram_rdata;
            end else begin
                tail_d = ram_rdata;
            end
        end
        occ_d = occ_mp + {1'b0, push};
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            rbin_q      <= rbin_d;
            rptr_gray_q <= rptr_gray_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

`ifdef MPEG_FIFO_BYTESWAP_EN
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mpeg_fifo_rd_ctrl: byteswap needs DATA_WIDTH == 32");
    end
    assign data = byte_rev32(head_q);
`else
    assign data = head_q;
`endif

endmodule
